// File: rtl/da_bitslicer.sv
// rtl/da_bitslicer.sv - bit-serial sequencer feeding the distributed-arithmetic FIR core
// Optional sample-line flush port enabled by defining DA_FLUSH_EN.
module da_bitslicer #(
    parameter int BANKS         = 8,
    parameter int TAPS_PER_BANK = 8,
    parameter int SAMPLE_W      = 16,
    parameter int ACC_W         = 38,
    parameter int ACC_SETTLE    = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [SAMPLE_W-1:0]            s_data,
    input  logic                           cload,
`ifdef DA_FLUSH_EN
    input  logic                           flush,
`endif
    output logic [BANKS*TAPS_PER_BANK-1:0] addr,
    output logic                           da_clr,
    output logic                           da_start,
    input  logic                           da_done,
    input  logic [ACC_W-1:0]               da_acc,
    output logic                           y_valid,
    input  logic                           y_ready,
    output logic [ACC_W-1:0]               y_data,
    output logic                           busy
);

    localparam int NT = BANKS * TAPS_PER_BANK;
    localparam int BW = $clog2(SAMPLE_W);
    localparam int CW = $clog2(ACC_SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ISSUE, S_WAIT, S_SETTLE, S_OUT
    } state_t;

    state_t              state, state_nx;
    logic [SAMPLE_W-1:0] taps [NT];
    logic [BW-1:0]       b_idx;
    logic [BW-1:0]       sel_idx;
    logic [CW-1:0]       cnt;
    logic [NT-1:0]       slice_nx;
    logic                flush_now;
    logic                accept;
    logic                last_done;

`ifdef DA_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign accept    = s_valid & s_ready;
    assign last_done = (state == S_WAIT) && da_done && (b_idx == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_CLR;
            S_CLR:    state_nx = S_ISSUE;
            S_ISSUE:  state_nx = S_WAIT;
            S_WAIT:   if (da_done) state_nx = (b_idx == '0) ? S_SETTLE : S_ISSUE;
            S_SETTLE: if (cnt == '0) state_nx = S_OUT;
            S_OUT:    if (y_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // resetn gates s_ready so nothing is accepted while reset is held.
    always_comb begin
        s_ready  = (state == S_IDLE) && !cload && !flush_now && resetn;
        da_clr   = (state == S_CLR);
        da_start = (state == S_ISSUE);
        busy     = (state != S_IDLE);
    end

    // Slice for the next ISSUE: MSB when leaving CLR, else one bit below the current slice.
    always_comb begin
        sel_idx = (state == S_CLR) ? BW'(SAMPLE_W - 1) : (b_idx - 1'b1);
        for (int n = 0; n < NT; n++) begin
            slice_nx[n] = taps[n][sel_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int n = 0; n < NT; n++) taps[n] <= '0;
        end else if (accept) begin
            for (int n = NT - 1; n > 0; n--) taps[n] <= taps[n-1];
            taps[0] <= s_data;
        end else if ((state == S_IDLE) && flush_now) begin
            for (int n = 0; n < NT; n++) taps[n] <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_idx <= BW'(SAMPLE_W - 1);
            addr  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_CLR: begin
                    b_idx <= BW'(SAMPLE_W - 1);
                    addr  <= slice_nx;
                end
                S_WAIT: begin
                    if (last_done) begin
                        addr <= '0;
                        cnt  <= CW'(ACC_SETTLE);
                    end else if (da_done) begin
                        b_idx <= b_idx - 1'b1;
                        addr  <= slice_nx;
                    end
                end
                S_SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if ((state == S_SETTLE) && (cnt == '0)) begin
            y_valid <= 1'b1;
            y_data  <= da_acc;
        end else if ((state == S_OUT) && y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_da_bitslicer.sv
// tb/tb_da_bitslicer.sv - directed self-checking bench for da_bitslicer
module tb_da_bitslicer;
    localparam int ACC_W = 38;
    localparam int NT    = 64;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [15:0]       s_data = '0;
    logic              cload = 1'b0;
`ifdef DA_FLUSH_EN
    logic              flush = 1'b0;
`endif
    logic [NT-1:0]     addr;
    logic              da_clr;
    logic              da_start;
    logic              da_done = 1'b0;
    logic [ACC_W-1:0]  da_acc = 38'h2A_DEAD_BEEF;
    logic              y_valid;
    logic              y_ready = 1'b0;
    logic [ACC_W-1:0]  y_data;
    logic              busy;

    da_bitslicer dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cload(cload),
`ifdef DA_FLUSH_EN
        .flush(flush),
`endif
        .addr(addr), .da_clr(da_clr), .da_start(da_start), .da_done(da_done),
        .da_acc(da_acc), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the da core: done two cycles after each start; logs each slice address.
    int          pend = 0;
    bit          spur = 1'b0;
    int          slice_cnt = 0;
    int          clr_cnt = 0;
    int          done_cyc = 0;
    logic [63:0] addr_log [16];

    always @(negedge clk) begin
        if (!resetn) begin
            pend    = 0;
            da_done = 1'b0;
        end else begin
            da_done = spur;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    da_done  = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (da_start) begin
                pend = 2;
                if (slice_cnt < 16) addr_log[slice_cnt] = addr;
                slice_cnt++;
            end
            if (da_clr) clr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic clear_mon();
        slice_cnt = 0;
        clr_cnt   = 0;
        for (int i = 0; i < 16; i++) addr_log[i] = '1;
    endtask

    task automatic send(input logic [15:0] v, output int acc_cyc);
        s_data  = v;
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (s_ready) break;
            tick();
        end
        if (!s_ready) chk("send_ready", 64'(s_ready), 64'd1);
        tick();
        acc_cyc = cyc;
        s_valid = 1'b0;
    endtask

    task automatic wait_y(output int y_cyc);
        for (int i = 0; i < 300; i++) begin
            if (y_valid) break;
            tick();
        end
        if (!y_valid) chk("y_timeout", 64'(y_valid), 64'd1);
        y_cyc = cyc;
    endtask

    task automatic release_y();
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    task automatic run(input logic [15:0] v);
        int a, y;
        send(v, a);
        wait_y(y);
        release_y();
    endtask

    function automatic logic [63:0] or_slices(input int lo, input int hi);
        logic [63:0] r = '0;
        for (int i = lo; i <= hi; i++) r = r | addr_log[i];
        return r;
    endfunction

    int a_cyc, y_cyc;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", addr, 64'd0);
        chk("rst_da_clr", 64'(da_clr), 64'd0);
        chk("rst_da_start", 64'(da_start), 64'd0);
        chk("rst_y_valid", 64'(y_valid), 64'd0);
        chk("rst_y_data", 64'(y_data), 64'd0);
        resetn = 1'b1;
        tick();
        chk("rel_s_ready", 64'(s_ready), 64'd1);

        // Impulse
        clear_mon();
        send(16'h0001, a_cyc);
        wait_y(y_cyc);
        chk("imp_clr_cnt", 64'(clr_cnt), 64'd1);
        chk("imp_slices", 64'(slice_cnt), 64'd16);
        chk("imp_hi_slices", or_slices(0, 14), 64'd0);
        chk("imp_b0_slice", addr_log[15], 64'h1);
        chk("imp_latency", 64'(y_cyc - a_cyc), 64'd52);
        chk("imp_settle", 64'(y_cyc - done_cyc), 64'd4);
        chk("imp_y_data", 64'(y_data), 64'h2A_DEAD_BEEF);
        release_y();
        chk("imp_idle", 64'(busy), 64'd0);

        // Spurious done and cload gating in IDLE
        spur = 1'b1;
        tick();
        tick();
        spur = 1'b0;
        tick();
        chk("spur_idle", 64'(busy), 64'd0);
        cload   = 1'b1;
        s_valid = 1'b1;
        tick();
        chk("cload_s_ready", 64'(s_ready), 64'd0);
        tick();
        chk("cload_no_accept", 64'(busy), 64'd0);
        s_valid = 1'b0;
        cload   = 1'b0;
        tick();

        // Sign slice
        do_reset();
        clear_mon();
        send(16'h8000, a_cyc);
        wait_y(y_cyc);
        chk("sign_first", addr_log[0], 64'h1);
        chk("sign_rest", or_slices(1, 15), 64'd0);
        release_y();

        // Shift through the full delay line
        do_reset();
        for (int v = 1; v <= 64; v++) run(16'(v));
        clear_mon();
        run(16'd65);
        chk("shift_b0", addr_log[15], 64'h5555_5555_5555_5555);
        chk("shift_b1", addr_log[14], 64'hCCCC_CCCC_CCCC_CCCC);
        chk("shift_b6", addr_log[9], 64'h3);
        chk("shift_b15", addr_log[0], 64'h0);

        // Backpressure on the output
        clear_mon();
        send(16'h0777, a_cyc);
        wait_y(y_cyc);
        da_acc  = 38'h01_2345_6789;
        s_valid = 1'b1;
        s_data  = 16'h0042;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_y_data", 64'(y_data), 64'h2A_DEAD_BEEF);
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_y_valid", 64'(y_valid), 64'd1);
        end
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        chk("bp_y_drop", 64'(y_valid), 64'd0);
        chk("bp_idle", 64'(busy), 64'd0);
        chk("bp_s_ready_back", 64'(s_ready), 64'd1);
        tick();
        chk("bp_next_accept", 64'(busy), 64'd1);
        s_valid = 1'b0;
        wait_y(y_cyc);
        chk("bp_new_y_data", 64'(y_data), 64'h01_2345_6789);
        release_y();
        da_acc = 38'h2A_DEAD_BEEF;

        // Reset in the middle of a sequence
        do_reset();
        run(16'h1234);
        clear_mon();
        s_data  = 16'h1234;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (slice_cnt == 9 && busy && !da_start) break;
            tick();
        end
        chk("mid_at_b7", 64'(slice_cnt), 64'd9);
        resetn = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_addr", addr, 64'd0);
        chk("mid_da_start", 64'(da_start), 64'd0);
        chk("mid_da_clr", 64'(da_clr), 64'd0);
        chk("mid_y_valid", 64'(y_valid), 64'd0);
        chk("mid_s_ready", 64'(s_ready), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        clear_mon();
        send(16'h0005, a_cyc);
        wait_y(y_cyc);
        chk("mid_b0", addr_log[15], 64'h1);
        chk("mid_b1", addr_log[14], 64'h0);
        chk("mid_b2", addr_log[13], 64'h1);
        chk("mid_b12", addr_log[3], 64'h0);
        chk("mid_b15", addr_log[0], 64'h0);
        release_y();

`ifdef DA_FLUSH_EN
        // Flush the delay line in IDLE
        do_reset();
        for (int i = 0; i < 8; i++) run(16'hFFFF);
        flush   = 1'b1;
        s_valid = 1'b1;
        #1;
        chk("flush_s_ready", 64'(s_ready), 64'd0);
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("flush_no_accept", 64'(busy), 64'd0);
        clear_mon();
        send(16'h0000, a_cyc);
        wait_y(y_cyc);
        chk("flush_slices", or_slices(0, 15), 64'd0);
        chk("flush_count", 64'(slice_cnt), 64'd16);
        release_y();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
